wb_hazard_tracker: RTL and testbench
====================================

Name: wb_hazard_tracker

Overview:
Consumer end of the EX-stage write-back address: takes the selected destination register (rt/rd already muxed in EX) plus write controls, and carries them through internal MEM and WB stage registers. Drives the register-file write port address/enable at WB and generates the EX operand forwarding selects. Raises the ID load-use stall request. Keeps a saturating stall counter for performance debug.

Parameters:
REG_ADDR_W, 5, register address width (32 GPRs; register 0 hard-wired zero)
CNT_W, 16, width of the stall event counter

Ports:
clk  input  1  system clock, all state on rising edge
rst_n  input  1  synchronous active-low reset
ex_valid  input  1  EX stage holds a real instruction (0 = bubble)
ex_wbadd  input  REG_ADDR_W  destination register selected in EX
ex_regwrite  input  1  EX instruction writes a GPR
ex_memread  input  1  EX instruction is a load
ex_flush  input  1  squash EX instruction (branch/jump taken); it must not enter MEM
ex_rs  input  REG_ADDR_W  rs operand address of EX instruction
ex_rt  input  REG_ADDR_W  rt operand address of EX instruction
id_rs  input  REG_ADDR_W  rs of instruction in ID
id_rt  input  REG_ADDR_W  rt of instruction in ID
id_uses_rt  input  1  ID instruction reads rt as a source
fwd_a  output  2  EX operand A select: 00 regfile, 10 MEM result, 01 WB result
fwd_b  output  2  EX operand B select, same encoding
stall  output  1  load-use stall request to PC/IF-ID (hold) and ID/EX (bubble)
mem_wbadd  output  REG_ADDR_W  destination held in MEM stage
wb_wbadd  output  REG_ADDR_W  regfile write address
wb_we  output  1  regfile write enable
stall_cnt  output  CNT_W  number of stall cycles since reset, saturating

Behaviour:
- Interface: single clock clk; reset rst_n is synchronous and active-low.
- Reset (rst_n=0 at a rising edge): MEM and WB entries cleared, so valid=0, wbadd=0, regwrite=0 and memread=0. stall_cnt=0.
- Reset effects while rst_n=0: wb_we=0, fwd_a=fwd_b=00, mem_wbadd=wb_wbadd=0. stall follows its combinational equation on the EX/ID inputs.
- Reset mid-operation discards all in-flight entries. No write is issued in the cycle after reset is released.
- Effective write: eff_we(stage) = valid & regwrite & (wbadd != 0). Writes to $0 never forward and never assert wb_we.
- Stage advance, every rising edge when rst_n=1:
  - MEM <= {ex_valid & ~ex_flush, ex_wbadd, ex_regwrite, ex_memread}.
  - WB <= MEM.
  - The block has no stall input. Bubbles arrive as ex_valid=0.
- Latency: an address presented at EX in cycle n is on mem_wbadd in n+1 and on wb_wbadd in n+2. wb_we in n+2 equals eff_we of that entry.
- wb_wbadd is registered WB.wbadd. wb_we = eff_we(WB).
- Forwarding (combinational from registered MEM/WB state and ex_rs/ex_rt). For operand A with ex_rs:
  - 10 if eff_we(MEM) & ~MEM.memread & MEM.wbadd==ex_rs.
  - else 01 if eff_we(WB) & WB.wbadd==ex_rs.
  - else 00.
  - Operand B is identical using ex_rt.
  - MEM has priority over WB when both match.
  - ex_rs/ex_rt equal to 0 always yield 00.
- Load in MEM matching an EX source selects 00. The stall rule guarantees this never occurs in legal operation; the bench asserts it never happens.
- stall (combinational) = ex_valid & ~ex_flush & ex_memread & eff_we-equivalent(ex_regwrite & ex_wbadd!=0) & (ex_wbadd==id_rs | (id_uses_rt & ex_wbadd==id_rt)).
- stall_cnt increments by 1 on each edge where stall=1. It holds at all ones (2^CNT_W-1).
- Flush and stall in the same cycle: flush wins, so stall=0.
- Simultaneous WB write and EX read of the same register is resolved by forwarding (01). The regfile is not required to write-before-read.

Decomposition:
- Shared package mips_pipe_pkg:
  - REG_ADDR_W.
  - FWD_RF=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10.
  - Stage entry typedef wb_entry_t {valid, wbadd, regwrite, memread}.
- One natural sub-module: fwd_sel. It is a combinational comparator taking (src, MEM entry, WB entry) -> 2-bit select and is instantiated twice, for operands A and B.
- The stage registers, stall logic and counter stay in the top module.

Test Plan:
- Reset: hold rst_n=0 for 2 cycles with ex_valid=1, ex_wbadd=5, ex_regwrite=1 -> wb_we=0, stall_cnt=0, fwd=00. After release, first wb_we=1 with wb_wbadd=5 occurs exactly 2 cycles later.
- Back-to-back ALU dependency: cycle0 EX writes $8. Cycle1 EX has ex_rs=8, ex_rt=8 -> fwd_a=fwd_b=10. Cycle2 with ex_rs=8 -> fwd_a=01.
- Double match priority: MEM and WB both hold $3 with regwrite=1, ex_rs=3 -> fwd_a=10. Set ex_rs=0 with WB.wbadd=0 and regwrite=1 -> fwd_a=00 and wb_we=0.
- Load-use: EX load writing $9 (memread=1). Case id_rs=9 -> stall=1. Case id_rt=9 with id_uses_rt=0 -> stall=0. Bubble next cycle -> stall_cnt increments by 1.
- Flush: ex_flush=1 with a load to $9 and id_rs=9 -> stall=0. No wb_we two cycles later.
- Counter saturation: with CNT_W=4, force 20 stall cycles -> stall_cnt=15 and holds.

Source files
------------

// File: rtl/mips_pipe_pkg.sv
// -----------------------------------------------------------------------------
// mips_pipe_pkg
//   Shared definitions for the write-back hazard tracking slice:
//     REG_ADDR_W  - GPR address width (32 GPRs, $0 hard-wired to zero)
//     fwd_t       - EX operand forwarding select encoding
//     wb_entry_t  - one pipeline stage's write-back descriptor
//     eff_we()    - "this stage will really write a GPR"
// -----------------------------------------------------------------------------
package mips_pipe_pkg;

  localparam int unsigned REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    FWD_RF  = 2'b00,
    FWD_WB  = 2'b01,
    FWD_MEM = 2'b10
  } fwd_t;

  typedef struct packed {
    logic                  valid;
    logic [REG_ADDR_W-1:0] wbadd;
    logic                  regwrite;
    logic                  memread;
  } wb_entry_t;

  // A write to $0 is architecturally a no-op, so it neither forwards nor
  // reaches the register file.
  function automatic logic eff_we(input wb_entry_t e);
    return e.valid & e.regwrite & (e.wbadd != '0);
  endfunction

endpackage

// File: rtl/wb_hazard_tracker_fwd_sel.sv
// -----------------------------------------------------------------------------
// fwd_sel
//   Combinational forwarding comparator for one EX source operand.
//   Ports:
//     i_src  - source register address read by the EX instruction
//     i_mem  - write-back descriptor currently held in MEM
//     i_wb   - write-back descriptor currently held in WB
//     o_sel  - 00 register file, 10 MEM result, 01 WB result
// -----------------------------------------------------------------------------
module fwd_sel
  import mips_pipe_pkg::*;
(
  input  logic [REG_ADDR_W-1:0] i_src,
  input  wb_entry_t             i_mem,
  input  wb_entry_t             i_wb,
  output logic [1:0]            o_sel
);

  logic w_mem_hit;
  logic w_wb_hit;
  fwd_t w_sel;

  always_comb begin
    w_mem_hit = eff_we(i_mem) & (i_mem.wbadd == i_src);
    w_wb_hit  = eff_we(i_wb)  & (i_wb.wbadd  == i_src);
    w_sel     = FWD_RF;
    if (i_src == '0) begin
      w_sel = FWD_RF;
    end else if (w_mem_hit) begin
      // A load in MEM has no result yet; the older WB value would be stale,
      // so fall back to the register file (unreachable when stalls are honoured).
      w_sel = i_mem.memread ? FWD_RF : FWD_MEM;
    end else if (w_wb_hit) begin
      w_sel = FWD_WB;
    end
  end

  assign o_sel = w_sel;

endmodule

// File: rtl/wb_hazard_tracker.sv
// -----------------------------------------------------------------------------
// wb_hazard_tracker
//   Carries the EX-stage destination register through MEM and WB stage
//   registers, drives the register-file write port at WB, produces EX operand
//   forwarding selects and the ID load-use stall request, and counts stall
//   cycles (saturating) for performance debug.
//   Ports:
//     clk, rst_n                 - clock, synchronous active-low reset
//     ex_valid/ex_flush          - EX holds a real instruction / squash it
//     ex_wbadd/ex_regwrite/ex_memread - EX write-back descriptor
//     ex_rs/ex_rt                - EX source operands (forwarding)
//     id_rs/id_rt/id_uses_rt     - ID source operands (load-use stall)
//     fwd_a/fwd_b                - EX operand selects (00 RF, 10 MEM, 01 WB)
//     stall                      - load-use stall request
//     mem_wbadd                  - destination held in MEM
//     wb_wbadd/wb_we             - register-file write port
//     stall_cnt                  - stall cycles since reset, saturating
// -----------------------------------------------------------------------------
module wb_hazard_tracker #(
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ex_valid,
  input  logic [REG_ADDR_W-1:0] ex_wbadd,
  input  logic                  ex_regwrite,
  input  logic                  ex_memread,
  input  logic                  ex_flush,
  input  logic [REG_ADDR_W-1:0] ex_rs,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic                  id_uses_rt,
  output logic [1:0]            fwd_a,
  output logic [1:0]            fwd_b,
  output logic                  stall,
  output logic [REG_ADDR_W-1:0] mem_wbadd,
  output logic [REG_ADDR_W-1:0] wb_wbadd,
  output logic                  wb_we,
  output logic [CNT_W-1:0]      stall_cnt
);

  import mips_pipe_pkg::*;

  wb_entry_t        r_mem;
  wb_entry_t        r_wb;
  wb_entry_t        w_ex_entry;
  logic [CNT_W-1:0] r_cnt;
  logic             w_stall;
  logic             w_ex_load_we;

  // A flushed instruction enters MEM as a bubble; its address is still
  // carried so mem_wbadd/wb_wbadd simply mirror what was presented.
  always_comb begin
    w_ex_entry.valid    = ex_valid & ~ex_flush;
    w_ex_entry.wbadd    = ex_wbadd;
    w_ex_entry.regwrite = ex_regwrite;
    w_ex_entry.memread  = ex_memread;
  end

  // Load-use: the ID consumer would need the load result one cycle before it
  // exists. Flush wins over stall because the load never completes.
  always_comb begin
    w_ex_load_we = ex_valid & ~ex_flush & ex_memread & ex_regwrite &
                   (ex_wbadd != '0);
    w_stall      = w_ex_load_we &
                   ((ex_wbadd == id_rs) | (id_uses_rt & (ex_wbadd == id_rt)));
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_mem <= '0;
      r_wb  <= '0;
      r_cnt <= '0;
    end else begin
      r_mem <= w_ex_entry;
      r_wb  <= r_mem;
      if (w_stall && (r_cnt != '1)) begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  fwd_sel u_fwd_a (
    .i_src (ex_rs),
    .i_mem (r_mem),
    .i_wb  (r_wb),
    .o_sel (fwd_a)
  );

  fwd_sel u_fwd_b (
    .i_src (ex_rt),
    .i_mem (r_mem),
    .i_wb  (r_wb),
    .o_sel (fwd_b)
  );

  assign stall     = w_stall;
  assign mem_wbadd = r_mem.wbadd;
  assign wb_wbadd  = r_wb.wbadd;
  assign wb_we     = eff_we(r_wb);
  assign stall_cnt = r_cnt;

endmodule

// File: tb/tb_wb_hazard_tracker.sv
module tb_wb_hazard_tracker;

  localparam int CNT_W   = 4;
  localparam int CNT_MAX = 15;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ex_valid, ex_regwrite, ex_memread, ex_flush, id_uses_rt;
  logic [4:0] ex_wbadd, ex_rs, ex_rt, id_rs, id_rt;
  logic [1:0] fwd_a, fwd_b;
  logic       stall, wb_we;
  logic [4:0] mem_wbadd, wb_wbadd;
  logic [CNT_W-1:0] stall_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_hazard_tracker #(.REG_ADDR_W(5), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ex_valid   (ex_valid),
    .ex_wbadd   (ex_wbadd),
    .ex_regwrite(ex_regwrite),
    .ex_memread (ex_memread),
    .ex_flush   (ex_flush),
    .ex_rs      (ex_rs),
    .ex_rt      (ex_rt),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .id_uses_rt (id_uses_rt),
    .fwd_a      (fwd_a),
    .fwd_b      (fwd_b),
    .stall      (stall),
    .mem_wbadd  (mem_wbadd),
    .wb_wbadd   (wb_wbadd),
    .wb_we      (wb_we),
    .stall_cnt  (stall_cnt)
  );

  // ---------------- reference model: history of issued EX write-backs -----
  typedef struct { bit v; int a; bit rw; bit mr; } ment_t;
  ment_t hist[$];   // hist[$] is one cycle old (MEM), hist[$-1] two (WB)
  int    m_cnt;

  function automatic bit m_eff(ment_t e);
    return e.v && e.rw && (e.a != 0);
  endfunction

  function automatic int m_fwd(int src);
    ment_t m, w;
    m = hist[$];
    w = hist[$-1];
    if (src == 0) return 0;
    if (m_eff(m) && m.a == src) return m.mr ? 0 : 2;
    if (m_eff(w) && w.a == src) return 1;
    return 0;
  endfunction

  function automatic bit m_stall();
    return ex_valid && !ex_flush && ex_memread && ex_regwrite && ex_wbadd != 0 &&
           (ex_wbadd == id_rs || (id_uses_rt && ex_wbadd == id_rt));
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic tick();
    bit    s;
    ment_t z;
    z = '{0, 0, 0, 0};
    s = m_stall();
    @(posedge clk);
    if (!rst_n) begin
      hist.delete();
      hist.push_back(z);
      hist.push_back(z);
      m_cnt = 0;
    end else begin
      if (s && m_cnt < CNT_MAX) m_cnt++;
      hist.push_back('{ex_valid && !ex_flush, int'(ex_wbadd), ex_regwrite, ex_memread});
      void'(hist.pop_front());
    end
    #1;
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_fwd_a"},     32'(fwd_a),     32'(m_fwd(int'(ex_rs))));
    chk({tag, "_fwd_b"},     32'(fwd_b),     32'(m_fwd(int'(ex_rt))));
    chk({tag, "_stall"},     32'(stall),     32'(m_stall()));
    chk({tag, "_mem_wbadd"}, 32'(mem_wbadd), 32'(hist[$].a));
    chk({tag, "_wb_wbadd"},  32'(wb_wbadd),  32'(hist[$-1].a));
    chk({tag, "_wb_we"},     32'(wb_we),     32'(m_eff(hist[$-1])));
    chk({tag, "_stall_cnt"}, 32'(stall_cnt), 32'(m_cnt));
  endtask

  task automatic drive(input logic v, input logic [4:0] a, input logic rw, input logic mr,
                       input logic fl, input logic [4:0] ers, input logic [4:0] ert,
                       input logic [4:0] irs, input logic [4:0] irt, input logic iu);
    ex_valid = v; ex_wbadd = a; ex_regwrite = rw; ex_memread = mr; ex_flush = fl;
    ex_rs = ers; ex_rt = ert; id_rs = irs; id_rt = irt; id_uses_rt = iu;
  endtask

  // ---------------- directed vector table ----------------------------------
  typedef struct {
    logic v; logic [4:0] a; logic rw, mr, fl;
    logic [4:0] ers, ert, irs, irt; logic iu;
    logic [1:0] fa, fb; logic st; logic [4:0] ma, wa; logic we; logic [3:0] cnt;
  } vec_t;
  vec_t tbl[13];

  initial begin
    ment_t z;
    bit    ex_uses_rt;
    bit    prev_stall;
    bit    idv, idrw, idmr, idu;
    int    ida, idrs, idrt;
    bit    hazard;

    z = '{0, 0, 0, 0};
    hist.push_back(z);
    hist.push_back(z);
    m_cnt = 0;

    //          v a  rw mr fl ers ert irs irt iu  fa fb st ma wa we cnt
    tbl[0]  = '{1, 8, 1, 0, 0, 0, 0, 8, 8, 1,  0, 0, 0, 0, 0, 0, 0};
    tbl[1]  = '{1, 3, 1, 0, 0, 8, 8, 0, 0, 0,  2, 2, 0, 8, 0, 0, 0};
    tbl[2]  = '{1, 3, 1, 0, 0, 8, 3, 0, 0, 0,  1, 2, 0, 3, 8, 1, 0};
    tbl[3]  = '{1, 0, 1, 0, 0, 3, 8, 0, 0, 0,  2, 0, 0, 3, 3, 1, 0};
    tbl[4]  = '{0, 0, 0, 0, 0, 3, 0, 0, 0, 0,  1, 0, 0, 0, 3, 1, 0};
    tbl[5]  = '{1, 9, 1, 1, 0, 0, 0, 9, 0, 0,  0, 0, 1, 0, 0, 0, 0};
    tbl[6]  = '{0, 0, 0, 0, 0, 0, 0, 9, 0, 0,  0, 0, 0, 9, 0, 0, 1};
    tbl[7]  = '{1, 9, 1, 1, 0, 9, 0, 1, 9, 0,  1, 0, 0, 0, 9, 1, 1};
    tbl[8]  = '{1, 9, 1, 1, 1, 0, 0, 9, 9, 1,  0, 0, 0, 9, 0, 0, 1};
    tbl[9]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 9, 9, 1, 1};
    tbl[10] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 9, 0, 1};
    tbl[11] = '{1, 4, 1, 1, 0, 0, 0, 2, 4, 1,  0, 0, 1, 0, 0, 0, 1};
    tbl[12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 4, 0, 0, 2};

    // ---------------- reset behaviour and first write latency -------------
    rst_n = 1'b0;
    drive(1, 5, 1, 0, 0, 5, 5, 0, 0, 0);
    tick();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("rst_wb_we", 32'(wb_we), 32'd0);
      chk("rst_stall_cnt", 32'(stall_cnt), 32'd0);
      chk("rst_fwd_a", 32'(fwd_a), 32'd0);
      chk("rst_fwd_b", 32'(fwd_b), 32'd0);
      chk("rst_mem_wbadd", 32'(mem_wbadd), 32'd0);
      tick();
    end
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel0_wb_we", 32'(wb_we), 32'd0);
    tick();
    @(negedge clk);
    chk("rel1_wb_we", 32'(wb_we), 32'd0);
    chk("rel1_mem_wbadd", 32'(mem_wbadd), 32'd5);
    tick();
    @(negedge clk);
    chk("rel2_wb_we", 32'(wb_we), 32'd1);
    chk("rel2_wb_wbadd", 32'(wb_wbadd), 32'd5);

    // ---------------- table-driven directed sequence ----------------------
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 13; i++) begin
      drive(tbl[i].v, tbl[i].a, tbl[i].rw, tbl[i].mr, tbl[i].fl,
            tbl[i].ers, tbl[i].ert, tbl[i].irs, tbl[i].irt, tbl[i].iu);
      @(negedge clk);
      chk($sformatf("vec%0d_fwd_a", i),     32'(fwd_a),     32'(tbl[i].fa));
      chk($sformatf("vec%0d_fwd_b", i),     32'(fwd_b),     32'(tbl[i].fb));
      chk($sformatf("vec%0d_stall", i),     32'(stall),     32'(tbl[i].st));
      chk($sformatf("vec%0d_mem_wbadd", i), 32'(mem_wbadd), 32'(tbl[i].ma));
      chk($sformatf("vec%0d_wb_wbadd", i),  32'(wb_wbadd),  32'(tbl[i].wa));
      chk($sformatf("vec%0d_wb_we", i),     32'(wb_we),     32'(tbl[i].we));
      chk($sformatf("vec%0d_stall_cnt", i), 32'(stall_cnt), 32'(tbl[i].cnt));
      tick();
    end

    // ---------------- counter saturation ----------------------------------
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    rst_n = 1'b1;
    drive(1, 7, 1, 1, 0, 0, 0, 7, 0, 0);
    for (int i = 0; i < 23; i++) begin
      @(negedge clk);
      chk($sformatf("sat%0d_stall", i), 32'(stall), 32'd1);
      chk($sformatf("sat%0d_cnt", i), 32'(stall_cnt), 32'((i < CNT_MAX) ? i : CNT_MAX));
      tick();
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("sat_hold_cnt", 32'(stall_cnt), 32'(CNT_MAX));
    tick();

    // ---------------- randomized legal pipeline vs model ------------------
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    prev_stall = 0;
    idv = 0; ida = 0; idrw = 0; idmr = 0; idrs = 0; idrt = 0; idu = 0;
    for (int c = 0; c < 3000; c++) begin
      rst_n = ($urandom_range(0, 79) != 0);
      if (prev_stall) begin
        // bubble into EX, ID instruction held
        drive(0, 5'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), 0,
              5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
              5'(idrs), 5'(idrt), idu);
        ex_uses_rt = 0;
      end else begin
        ex_uses_rt = idu;
        ex_valid = idv; ex_wbadd = 5'(ida); ex_regwrite = idrw; ex_memread = idmr;
        ex_rs = 5'(idrs); ex_rt = 5'(idrt);
        ex_flush = ($urandom_range(0, 11) == 0);
        idv  = ($urandom_range(0, 7) != 0);
        ida  = $urandom_range(0, 7);
        idrw = ($urandom_range(0, 3) != 0);
        idmr = ($urandom_range(0, 2) == 0);
        idrs = $urandom_range(0, 7);
        idrt = $urandom_range(0, 7);
        idu  = 1'($urandom);
        id_rs = 5'(idrs); id_rt = 5'(idrt); id_uses_rt = idu;
      end
      @(negedge clk);
      check_model("rnd");
      hazard = ex_valid && !ex_flush && m_eff(hist[$]) && hist[$].mr &&
               (hist[$].a == int'(ex_rs) || (ex_uses_rt && hist[$].a == int'(ex_rt)));
      chk("rnd_load_in_mem_hazard", 32'(hazard), 32'd0);
      prev_stall = stall;
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
